uart_rx_deframer: RTL and testbench
===================================

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal values >= 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous reset, active-low (rst==0 at a clk edge resets the block).
REQ-004 SHALL have port: rx  input  1  asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-005 SHALL have port: read_nic  input  1  one-cycle pulse from the OS acknowledging the current byte.
REQ-006 SHALL have port: data_out  output  8  last received byte.
REQ-007 SHALL have port: read_nic_i  output  1  level interrupt to the OS: byte available.
REQ-008 SHALL have port: frame_err  output  1  sticky: last frame had stop bit == 0.
REQ-009 SHALL have port: overrun  output  1  sticky: a byte overwrote an unacknowledged byte.
REQ-010 SHALL have port: parity_err  output  1  sticky parity error (see Configuration).
REQ-011 SHALL have port: busy  output  1  high whenever state != IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); 2-cycle input latency.
REQ-013 SHALL implement states IDLE, START, DATA, [PARITY], STOP, WAIT_IDLE with one bit-period counter (width $clog2(CLKS_PER_BIT)) and 3-bit bit index.
REQ-014 IDLE: on rx_s==0, SHALL clear counter and go to START.
REQ-015 START: at count CLKS_PER_BIT/2-1, SHALL go to DATA (counter cleared) if rx_s==0, else return to IDLE (glitch rejected, no flags changed).
REQ-016 DATA: every CLKS_PER_BIT cycles SHALL sample rx_s into shift register bit[index], LSB first; after index 7 SHALL go to PARITY (macro defined) or STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, if rx_s==1 SHALL load data_out, set read_nic_i on the next cycle, clear frame_err, go to IDLE.
REQ-018 STOP with rx_s==0 SHALL discard the byte (data_out, read_nic_i unchanged), set frame_err, go to WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL remain until rx_s==1, then go to IDLE (no retrigger on a break condition).
REQ-020 read_nic pulse SHALL clear read_nic_i, overrun and parity_err on the following cycle; frame_err cleared by read_nic or next good frame.
REQ-021 A good frame completing while read_nic_i==1 and read_nic==0 SHALL overwrite data_out and set overrun.
REQ-022 read_nic coincident with good-frame completion: new byte loaded, read_nic_i stays 1, overrun not set.
REQ-023 read_nic while read_nic_i==0 SHALL have no effect.

Reset
REQ-024 On rst==0 SHALL force: state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, read_nic_i 0, frame_err 0, overrun 0, parity_err 0, busy 0.
REQ-025 Reset mid-frame SHALL discard the partial byte; reception resumes on the next falling edge after rst returns high.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is 8E1; PARITY state samples one bit after data; on mismatch with even parity of the byte SHALL still deliver the byte and set parity_err.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame 8N1, parity_err tied to 0.

Verification (CLKS_PER_BIT=16)
REQ-028 Send 8'hA5 8N1 -> data_out==8'hA5, read_nic_i==1 within 2+8+8*16+16+2 cycles of start edge; frame_err, overrun 0.
REQ-029 rx low for 4 cycles then high -> returns to IDLE, read_nic_i stays 0, busy drops within 10 cycles.
REQ-030 Send 8'h3C with stop bit 0, hold rx low 50 cycles -> frame_err==1, read_nic_i==0, busy until rx high.
REQ-031 Send 8'h11 then 8'h22 without read_nic -> data_out==8'h22, overrun==1; read_nic pulse -> read_nic_i==0, overrun==0.
REQ-032 rst low during bit 3 of 8'hFF, then send 8'h5A -> single interrupt, data_out==8'h5A.
REQ-033 UART_RX_PARITY_EN defined, send 8'h07 with parity bit 0 -> data_out==8'h07, read_nic_i==1, parity_err==1.

Source files
------------

// File: rtl/uart_rx_deframer.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling, 8N1 (or 8E1 with
// UART_RX_PARITY_EN defined), byte/interrupt handshake with sticky error flags.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       read_nic,
  output logic [7:0] data_out,
  output logic       read_nic_i,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic rx_meta, rx_s;
  logic [7:0] shift;
  logic sample_bit, good_frame, bad_frame, ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic sample_par, par_bit;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    sample_bit = 1'b0;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      // Re-check the line half a bit in so short glitches are rejected.
      START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n      = '0;
        sample_bit = 1'b1;
        idx_n      = idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx == 3'd7) state_n = PARITY;
`else
        if (idx == 3'd7) state_n = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        cnt_n      = '0;
        sample_par = 1'b1;
        state_n    = STOP;
      end
`endif
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        if (rx_s) begin
          good_frame = 1'b1;
          state_n    = IDLE;
        end else begin
          bad_frame = 1'b1;
          state_n   = WAIT_IDLE;
        end
      end
      // Hold off during a break so a long low line does not start a new frame.
      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign ack  = read_nic & read_nic_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift      <= '0;
      data_out   <= '0;
      read_nic_i <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sample_bit) shift[idx] <= rx_s;
      if (good_frame) data_out <= shift;

      if (good_frame)  read_nic_i <= 1'b1;
      else if (ack)    read_nic_i <= 1'b0;

      if (bad_frame)       frame_err <= 1'b1;
      else if (good_frame) frame_err <= 1'b0;
      else if (ack)        frame_err <= 1'b0;

      // A coincident acknowledge consumes the old byte, so no overrun then.
      if (good_frame && read_nic_i && !read_nic) overrun <= 1'b1;
      else if (ack)                              overrun <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (sample_par) par_bit <= rx_s;
      if (good_frame && (par_bit != ^shift)) parity_err <= 1'b1;
      else if (ack)                          parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLKS_PER_BIT=16: frame table plus
// hand sequences for glitch, break, reset mid-frame and parity.
module tb_uart_rx_deframer;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst, rx, read_nic;
  logic [7:0] data_out;
  logic       read_nic_i, frame_err, overrun, parity_err, busy;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .read_nic(read_nic),
    .data_out(data_out), .read_nic_i(read_nic_i), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int irq_total = 0;
  logic rdy_q = 1'b0;

  always @(posedge clk) begin
    if (read_nic_i && !rdy_q) irq_total++;
    rdy_q <= read_nic_i;
  end

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         ack;
    logic [7:0] exp_d;
    bit         exp_rdy;
    bit         exp_ferr;
    bit         exp_ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par,
                            input bit end_level);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`else
    if (bad_par) rx = 1'b1;
`endif
    drive_bit(stop);
    rx = end_level;
  endtask

  task automatic pulse_ack;
    @(posedge clk); #1;
    read_nic = 1'b1;
    @(posedge clk); #1;
    read_nic = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int irq0;
    tbl[0] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; rx = 1'b1; read_nic = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst data_out", data_out, 8'h00);
    chk("rst read_nic_i", read_nic_i, 1'b0);
    chk("rst frame_err", frame_err, 1'b0);
    chk("rst overrun", overrun, 1'b0);
    chk("rst parity_err", parity_err, 1'b0);
    chk("rst busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) @(posedge clk); #1;

    // First byte with latency bound measured from the start edge.
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
      begin
        while (!read_nic_i && n < 200) begin
          @(posedge clk); #1;
          n++;
        end
      end
    join
    chk("A5 latency ok", (n <= 2 + 8 + 8 * CPB + CPB + 2), 1'b1);
    @(negedge clk);
    chk("A5 data_out", data_out, 8'hA5);
    chk("A5 read_nic_i", read_nic_i, 1'b1);
    chk("A5 frame_err", frame_err, 1'b0);
    chk("A5 overrun", overrun, 1'b0);
    pulse_ack();
    chk("A5 ack read_nic_i", read_nic_i, 1'b0);

    // Frame table: overrun, bad stop, error clearing, acknowledge.
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      send_frame(tbl[r].d, tbl[r].stop, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d data_out", r), data_out, tbl[r].exp_d);
      chk($sformatf("row%0d read_nic_i", r), read_nic_i, tbl[r].exp_rdy);
      chk($sformatf("row%0d frame_err", r), frame_err, tbl[r].exp_ferr);
      chk($sformatf("row%0d overrun", r), overrun, tbl[r].exp_ovr);
      chk($sformatf("row%0d busy", r), busy, 1'b0);
      if (tbl[r].ack) begin
        pulse_ack();
        chk($sformatf("row%0d ack read_nic_i", r), read_nic_i, 1'b0);
        chk($sformatf("row%0d ack overrun", r), overrun, 1'b0);
      end
    end
`ifndef UART_RX_PARITY_EN
    chk("no-parity parity_err", parity_err, 1'b0);
`endif

    // Glitch: 4 cycles low is rejected in START.
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("glitch busy high", busy, 1'b1);
    rx = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("glitch busy drop", busy, 1'b0);
    chk("glitch read_nic_i", read_nic_i, 1'b0);
    chk("glitch frame_err", frame_err, 1'b0);

    // Break: stop bit 0 and line held low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("break frame_err", frame_err, 1'b1);
    chk("break read_nic_i", read_nic_i, 1'b0);
    chk("break busy held", busy, 1'b1);
    #1 rx = 1'b1;
    n = 0;
    while (busy && n < 6) begin
      @(posedge clk); #1;
      n++;
    end
    chk("break busy drop", busy, 1'b0);
    pulse_ack();
    chk("idle ack frame_err kept", frame_err, 1'b1);
    chk("idle ack read_nic_i", read_nic_i, 1'b0);

    // Reset during bit 3 of 8'hFF, then a clean 8'h5A.
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst busy", busy, 1'b0);
    chk("midrst frame_err", frame_err, 1'b0);
    chk("midrst data_out", data_out, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6 * CPB) @(posedge clk); #1;
    irq0 = irq_total;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst irq count", irq_total - irq0, 1);
    chk("midrst data_out 5A", data_out, 8'h5A);
    chk("midrst read_nic_i", read_nic_i, 1'b1);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    @(posedge clk); #1;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("par data_out", data_out, 8'h07);
    chk("par read_nic_i", read_nic_i, 1'b1);
    chk("par parity_err", parity_err, 1'b1);
    pulse_ack();
    chk("par ack parity_err", parity_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
